// File: rtl/alu_addsub_pipe_pkg.sv
// Shared ALU types: operation encoding and the condition-code bundle that the
// condition-code register also consumes.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
        logic cf;
    } cc_flags_t;

endpackage

// File: rtl/alu_addsub_pipe_if.sv
// Request/response handshake bundle for the pipelined adder/subtractor.
interface alu_addsub_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cf;
    logic             of;
    logic             zf;
    logic             sf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cf, of, zf, sf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cf, of, zf, sf
    );
endinterface

// File: rtl/alu_addsub_pipe_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from the 1-bit full-adder cell;
// also exposes the carry into its top bit for signed-overflow detection.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa_cell u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined two's-complement add/sub: the carry chain is cut into STAGES chunks
// with a register rank after each; one global advance moves every rank at once.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_addsub_pipe_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
        $error("alu_addsub_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic                         adv;
    logic [WIDTH-1:0]             b_cap;
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            op_q, op_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0]            zero_q, zero_d;
    logic                         msbc_q, msbc_d;
    logic [STAGES-1:0][CHUNK-1:0] sum_c;
    logic [STAGES-1:0][CHUNK-1:0] res_out;
    logic [STAGES-1:0]            cout_c;
    logic                         cmsb_last;
    logic [WIDTH-1:0]             res_full;
    cc_flags_t                    flags;

    assign adv         = !vld_q[LAST] || io.out_ready;
    assign io.in_ready = adv;
    assign b_cap       = (alu_op_e'(io.op) == OP_SUB) ? ~io.b : io.b;

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        logic [CHUNK-1:0] a_in, b_in;
        logic             cin;
        logic             c_msb;

        if (j == 0) begin : g_cap
            assign a_in = io.a[CHUNK-1:0];
            assign b_in = b_cap[CHUNK-1:0];
            assign cin  = io.op;
        end else begin : g_dly
            // Operand chunk j waits j ranks before its adder sees it.
            logic [j:1][CHUNK-1:0] a_q, a_d, b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d[1] = io.a[j*CHUNK +: CHUNK];
                    b_d[1] = b_cap[j*CHUNK +: CHUNK];
                    for (int i = 2; i <= j; i++) begin
                        a_d[i] = a_q[i-1];
                        b_d[i] = b_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_in = a_q[j];
            assign b_in = b_q[j];
            assign cin  = carry_q[j-1];
        end

        add_chunk #(.W(CHUNK)) u_add (
            .a    (a_in),
            .b    (b_in),
            .cin  (cin),
            .sum  (sum_c[j]),
            .cout (cout_c[j]),
            .c_msb(c_msb)
        );

        if (j == LAST) begin : g_msb
            assign cmsb_last = c_msb;
        end else begin : g_nomsb
            logic unused_c_msb;
            assign unused_c_msb = c_msb;
        end

        // Finished result chunk j rides along from rank j to the output rank.
        logic [LAST:j][CHUNK-1:0] r_q, r_d;

        always_comb begin
            r_d = r_q;
            if (adv) begin
                r_d[j] = sum_c[j];
                for (int i = j + 1; i <= LAST; i++) begin
                    r_d[i] = r_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_q <= '0;
            else        r_q <= r_d;
        end

        assign res_out[j] = r_q[LAST];
    end

    always_comb begin
        vld_d   = vld_q;
        op_d    = op_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        msbc_d  = msbc_q;
        if (adv) begin
            vld_d[0]  = io.in_valid;
            op_d[0]   = io.op;
            carry_d   = cout_c;
            zero_d[0] = (sum_c[0] == '0);
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]  = vld_q[k-1];
                op_d[k]   = op_q[k-1];
                zero_d[k] = zero_q[k-1] && (sum_c[k] == '0);
            end
            msbc_d = cmsb_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            op_q    <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            msbc_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            msbc_q  <= msbc_d;
        end
    end

    assign res_full = res_out;

    // Outputs are forced to zero whenever the output rank holds a bubble.
    always_comb begin
        flags     = '0;
        io.result = '0;
        if (vld_q[LAST]) begin
            io.result = res_full;
            flags.zf  = zero_q[LAST];
            flags.sf  = res_full[WIDTH-1];
            flags.of  = carry_q[LAST] ^ msbc_q;
            flags.cf  = (alu_op_e'(op_q[LAST]) == OP_SUB) ? !carry_q[LAST] : carry_q[LAST];
        end
    end

    assign io.out_valid = vld_q[LAST];
    assign io.zf        = flags.zf;
    assign io.sf        = flags.sf;
    assign io.of        = flags.of;
    assign io.cf        = flags.cf;
endmodule
